// File: rtl/pdm_pkg.sv
// Shared types and defaults for the multi-channel PDM deserializer.
package pdm_pkg;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_t;

  localparam int unsigned WORD_W_DEF     = 16;
  localparam int unsigned CLK_DIV_DEF    = 100;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned CHAN_W         = 1;

  // Packed width of one FIFO entry {chan, word}.
  function automatic int unsigned entry_w(input int unsigned word_w);
    return word_w + CHAN_W;
  endfunction

endpackage

// File: rtl/pdm_deserializer_mc_if.sv
// Valid/ready output stream carrying channel-tagged PDM words.
interface pdm_deserializer_mc_if #(
  parameter int unsigned WORD_W = pdm_pkg::WORD_W_DEF
);
  import pdm_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  chan_t             out_chan;

  modport master (
    output out_valid,
    output out_data,
    output out_chan,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_chan,
    output out_ready
  );

endinterface

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider; emits one-cycle L/R sample strobes at the end of each phase.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_pdm_clk,
  output logic o_strobe_l,
  output logic o_strobe_r
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned HALF  = CLK_DIV / 2;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_pdm_clk;

  always_comb begin
    w_cnt_d = '0;
    if (i_enable && (r_cnt != CNT_W'(CLK_DIV - 1))) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  // The clock register follows the next count so its phase lines up with r_cnt.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_pdm_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_pdm_clk <= i_enable && (w_cnt_d < CNT_W'(HALF));
    end
  end

  assign o_pdm_clk  = r_pdm_clk;
  assign o_strobe_l = i_enable && (r_cnt == CNT_W'(HALF - 1));
  assign o_strobe_r = i_enable && (r_cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/pdm_deserializer_mc.sv
// Mono/stereo PDM capture: per-channel MSB-first word packing into a show-ahead output FIFO.
module pdm_deserializer_mc
  import pdm_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  stereo,
  input  logic                  chan_sel,
  input  logic                  pdm_data_i,
  output logic                  pdm_clk_o,
  output logic                  pdm_lrsel_o,
  output logic                  overflow,
  pdm_deserializer_mc_if.master out_if
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BCNT_W = $clog2(WORD_W);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(WORD_W - 1);
  localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);

  typedef struct packed {
    chan_t             chan;
    logic [WORD_W-1:0] word;
  } entry_t;

  logic              w_strobe_l, w_strobe_r;
  logic              w_take_l, w_take_r, w_done_l, w_done_r;
  logic              w_push, w_pop, w_push_ok, w_empty, w_full, w_en_rise;
  logic [WORD_W-1:0] w_sr_l_d, w_sr_r_d;
  entry_t            w_push_entry, w_head;

  logic              r_en_q;
  logic              r_stereo;
  chan_t             r_chan_sel;
  logic [WORD_W-1:0] r_sr_l, r_sr_r;
  logic [BCNT_W-1:0] r_bcnt_l, r_bcnt_r;
  logic [PTR_W:0]    r_wptr, r_rptr;
  logic              r_overflow;
  entry_t            r_mem [FIFO_DEPTH];

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk      (clock),
    .i_rst_n    (reset_n),
    .i_enable   (enable),
    .o_pdm_clk  (pdm_clk_o),
    .o_strobe_l (w_strobe_l),
    .o_strobe_r (w_strobe_r)
  );

  always_comb begin
    w_en_rise = enable && !r_en_q;
    w_take_l  = w_strobe_l && (r_stereo || (r_chan_sel == CH_L));
    w_take_r  = w_strobe_r && (r_stereo || (r_chan_sel == CH_R));
    w_done_l  = w_take_l && (r_bcnt_l == BCNT_MAX);
    w_done_r  = w_take_r && (r_bcnt_r == BCNT_MAX);
    w_sr_l_d  = {r_sr_l[WORD_W-2:0], pdm_data_i};
    w_sr_r_d  = {r_sr_r[WORD_W-2:0], pdm_data_i};
    w_push    = w_done_l || w_done_r;
    // L and R strobes never coincide, so one push port is enough.
    if (w_done_r) begin
      w_push_entry = '{chan: CH_R, word: w_sr_r_d};
    end else begin
      w_push_entry = '{chan: CH_L, word: w_sr_l_d};
    end
    w_empty   = (r_wptr == r_rptr);
    w_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    w_pop     = !w_empty && out_if.out_ready;
    w_push_ok = w_push && (!w_full || w_pop);
    w_head    = r_mem[r_rptr[PTR_W-1:0]];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_en_q     <= 1'b0;
      r_stereo   <= 1'b0;
      r_chan_sel <= CH_L;
    end else begin
      r_en_q <= enable;
      if (w_en_rise) begin
        r_stereo   <= stereo;
        r_chan_sel <= chan_t'(chan_sel);
      end
    end
  end

  // Disabling discards any partially assembled words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sr_l   <= '0;
      r_sr_r   <= '0;
      r_bcnt_l <= '0;
      r_bcnt_r <= '0;
    end else if (!enable) begin
      r_sr_l   <= '0;
      r_sr_r   <= '0;
      r_bcnt_l <= '0;
      r_bcnt_r <= '0;
    end else begin
      if (w_take_l) begin
        r_sr_l   <= w_sr_l_d;
        r_bcnt_l <= w_done_l ? '0 : r_bcnt_l + BCNT_W'(1);
      end
      if (w_take_r) begin
        r_sr_r   <= w_sr_r_d;
        r_bcnt_r <= w_done_r ? '0 : r_bcnt_r + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
      if (w_en_rise) begin
        r_overflow <= 1'b0;
      end else if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr[PTR_W-1:0]] <= w_push_entry;
  end

  assign overflow         = r_overflow;
  assign pdm_lrsel_o      = r_stereo ? 1'b0 : r_chan_sel;
  assign out_if.out_valid = !w_empty;
  assign out_if.out_data  = w_empty ? '0 : w_head.word;
  assign out_if.out_chan  = w_empty ? CH_L : w_head.chan;

endmodule

// File: doc/pdm_deserializer_mc.md
Name: pdm_deserializer_mc

Overview:
Parametrised successor to the single-channel PDM front end. Generates the microphone clock by dividing the system clock, samples one or two PDM microphones sharing a data line, and packs bits MSB-first into WORD_W-bit words. Completed words are tagged with their channel and queued in a small show-ahead FIFO with a valid/ready output. The block sits between the board-level microphone pins and the audio sample memory writer.

Parameters:
WORD_W, 16, bits per output word (2..32)
CLK_DIV, 100, system clocks per PDM clock period (even, >=4); 100 gives 1 MHz from 100 MHz
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  capture enable; low = idle, PDM clock stopped
stereo  in  1  1 = capture both channels, 0 = mono
chan_sel  in  1  mono channel select (0 = L, 1 = R)
pdm_data_i  in  1  shared microphone data line
pdm_clk_o  out  1  microphone clock
pdm_lrsel_o  out  1  microphone L/R select pin
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  WORD_W  FIFO head word
out_chan  out  1  channel of head word (0 = L, 1 = R)
overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (async, reset_n=0): all outputs 0; divider count, shift registers, bit counters, FIFO pointers and overflow cleared.
- stereo/chan_sel are latched into mode registers on the enable 0->1 edge. Changes while enabled are ignored.
- Divider: cnt runs 0..CLK_DIV-1 and wraps while enabled. pdm_clk_o is registered: 1 when cnt < CLK_DIV/2, else 0. When enable=0, cnt is held at 0 and pdm_clk_o is 0.
- Sample strobes (one cycle each):
  - L at cnt == CLK_DIV/2-1 (last cycle of the high phase).
  - R at cnt == CLK_DIV-1 (last cycle of the low phase).
- Mono: pdm_lrsel_o = latched chan_sel; only that channel's strobe samples. Stereo: pdm_lrsel_o = 0; both strobes sample into separate per-channel shift registers.
- Shift: sr <= {sr[WORD_W-2:0], pdm_data_i}. Per-channel bit counter runs 0..WORD_W-1. On the strobe with counter == WORD_W-1, the completed word ({chan, new sr value}) is pushed and the counter wraps to 0. There are no gaps between words.
- FIFO:
  - Show-ahead; out_valid = not empty; out_data/out_chan come from the head.
  - Pop on out_valid & out_ready.
  - Latency: out_valid rises the cycle after the completing strobe when the FIFO was empty.
  - Push while full and no pop in the same cycle: word dropped, overflow <= 1.
  - Push and pop in the same cycle while full: both accepted, no overflow.
  - Stereo ordering: L word always precedes its R word.
- enable 1->0: on the next cycle, divider, shift registers and bit counters are cleared and partial words are discarded. FIFO contents are kept and remain drainable. overflow clears on the enable 0->1 edge or on reset.
- reset_n asserted mid-word or mid-handshake: immediate clear; out_valid drops asynchronously.

Decomposition:
- Package pdm_pkg:
  - typedef chan_t (1-bit enum CH_L=0, CH_R=1)
  - parameterised struct/localparam widths for FIFO entry {chan, word}
  - localparam defaults for WORD_W and CLK_DIV
- Sub-module pdm_clk_gen (divider, pdm_clk_o, L/R strobes).
- The FIFO stays inline (reg array plus pointers with an extra wrap bit).

Test Plan (CLK_DIV=4, WORD_W=8, FIFO_DEPTH=4 unless noted):
- Mono L, serial pattern 0xA5 on L strobes, out_ready=1 -> out_data=0xA5, out_chan=0. First L strobe is at enabled cycle 1, so out_valid pulses at cycle 30 for one cycle.
- Stereo, L bits 0x3C, R bits 0xC3 -> two entries in order (0, 0x3C) then (1, 0xC3). R becomes valid 2 cycles after L; pdm_lrsel_o=0 throughout.
- out_ready=0, stereo, 3 word pairs (6 words) -> first 4 kept, 2 dropped, overflow=1. Draining yields the 4 oldest words in order. overflow stays 1 until enable is toggled.
- Full FIFO with out_ready=1 in the exact cycle of a push -> no drop, overflow stays 0, count unchanged.
- Drop enable after 5 bits, re-enable with chan_sel=1 -> partial word discarded, pdm_clk_o low while disabled, pdm_lrsel_o=1. Next word 0x81 arrives with out_chan=1.
- Assert reset_n=0 mid-word with 2 entries queued -> out_valid=0, overflow=0 and pdm_clk_o=0 immediately. After release with enable=1, the first word decodes correctly.
